// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM state encoding and instruction filler constant.
package core_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD,
    FETCH_DRAIN
  } fetch_state_e;

  // Word presented to the decoder when the slot holds an access fault.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : core_pkg

// File: rtl/core_fetch.sv
// Instruction fetch unit: PC register, single-outstanding memory read and a
// one-entry instruction slot, with exec-driven redirects that drop stale responses.
module core_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_fault,
  input  logic        exec_ready
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic         instr_valid_q;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic         fetch_fault_q;

  logic [31:0]  redirect_tgt;
  logic         unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Request outputs depend only on registered state, never on req_ready.
  assign req_valid   = (state_q == FETCH_REQ);
  assign req_addr    = pc_q;

  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_fault = fetch_fault_q;

  // NOTE: every register here is written with <= so all updates in one edge
  // see the pre-edge values of state_q/pc_q, which the transitions rely on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FETCH_IDLE;
      pc_q          <= RESET_VEC;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_VEC;
      fetch_fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH_IDLE: begin
          if (redirect) begin
            pc_q <= redirect_tgt;
          end
          state_q <= fetch_en ? FETCH_REQ : FETCH_IDLE;
        end

        FETCH_REQ: begin
          if (redirect) begin
            pc_q    <= redirect_tgt;
            // An accepted request already carries the old PC; its response is owed.
            state_q <= req_ready ? FETCH_DRAIN : FETCH_REQ;
          end else if (req_ready) begin
            state_q <= FETCH_WAIT;
          end
        end

        FETCH_WAIT: begin
          if (redirect) begin
            pc_q    <= redirect_tgt;
            state_q <= rsp_valid ? FETCH_REQ : FETCH_DRAIN;
          end else if (rsp_valid) begin
            instr_valid_q <= 1'b1;
            instr_q       <= rsp_err ? NOP_INSTR : rsp_data;
            instr_pc_q    <= pc_q;
            fetch_fault_q <= rsp_err;
            state_q       <= FETCH_HOLD;
          end
        end

        FETCH_HOLD: begin
          if (redirect) begin
            pc_q          <= redirect_tgt;
            instr_valid_q <= 1'b0;
            state_q       <= fetch_en ? FETCH_REQ : FETCH_IDLE;
          end else if (exec_ready) begin
            pc_q          <= pc_q + 32'd4;
            instr_valid_q <= 1'b0;
            state_q       <= fetch_en ? FETCH_REQ : FETCH_IDLE;
          end
        end

        FETCH_DRAIN: begin
          if (redirect) begin
            pc_q <= redirect_tgt;
          end
          if (rsp_valid) begin
            state_q <= fetch_en ? FETCH_REQ : FETCH_IDLE;
          end
        end

        default: state_q <= FETCH_IDLE;
      endcase
    end
  end

endmodule : core_fetch

// File: tb/tb_core_fetch.sv
// Directed self-checking bench for core_fetch; memory responses are driven by hand.
module tb_core_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;
  logic        exec_ready;

  int vectors     = 0;
  int miscompares = 0;

  core_fetch #(.RESET_VEC(32'h8000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .fetch_fault (fetch_fault),
    .exec_ready  (exec_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_valid"},   32'(req_valid),   32'd0);
    check({tag, " req_addr"},    req_addr,         32'h8000_0000);
    check({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, " instr"},       instr,            32'h0);
    check({tag, " instr_pc"},    instr_pc,         32'h8000_0000);
    check({tag, " fetch_fault"}, 32'(fetch_fault), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = 32'h0;
    rsp_err     = 1'b0;
    exec_ready  = 1'b0;

    tick();
    tick();
    check_reset_outputs("reset");

    // Basic fetch with zero-wait memory.
    rst       = 1'b0;
    fetch_en  = 1'b1;
    req_ready = 1'b1;
    tick();
    check("first req_valid", 32'(req_valid), 32'd1);
    check("first req_addr", req_addr, 32'h8000_0000);
    tick();
    check("wait req_valid", 32'(req_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = 32'h0000_0013;
    tick();
    rsp_valid = 1'b0;
    check("hold instr_valid", 32'(instr_valid), 32'd1);
    check("hold instr", instr, 32'h0000_0013);
    check("hold instr_pc", instr_pc, 32'h8000_0000);
    check("hold fetch_fault", 32'(fetch_fault), 32'd0);

    // Exec stalls for five cycles: slot must stay put, no new request.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall instr_valid", 32'(instr_valid), 32'd1);
      check("stall instr", instr, 32'h0000_0013);
      check("stall instr_pc", instr_pc, 32'h8000_0000);
      check("stall req_valid", 32'(req_valid), 32'd0);
    end
    exec_ready = 1'b1;
    tick();
    exec_ready = 1'b0;
    check("release req_valid", 32'(req_valid), 32'd1);
    check("release req_addr", req_addr, 32'h8000_0004);
    check("release instr_valid", 32'(instr_valid), 32'd0);

    // Redirect while waiting: response owed to the old PC is dropped.
    tick();
    check("wait2 req_valid", 32'(req_valid), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0102;
    tick();
    redirect = 1'b0;
    check("drain req_valid", 32'(req_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    check("drop instr_valid", 32'(instr_valid), 32'd0);
    check("drop instr kept", instr, 32'h0000_0013);
    check("redir req_valid", 32'(req_valid), 32'd1);
    check("redir req_addr", req_addr, 32'h8000_0100);

    // Redirect coinciding with the response in WAIT.
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0200;
    rsp_valid   = 1'b1;
    rsp_data    = 32'h1111_1111;
    tick();
    redirect  = 1'b0;
    rsp_valid = 1'b0;
    check("coinc instr_valid", 32'(instr_valid), 32'd0);
    check("coinc req_valid", 32'(req_valid), 32'd1);
    check("coinc req_addr", req_addr, 32'h8000_0200);

    // Redirect in REQ before acceptance retargets the pending request.
    req_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0008;
    tick();
    redirect = 1'b0;
    check("req retarget valid", 32'(req_valid), 32'd1);
    check("req retarget addr", req_addr, 32'h8000_0008);

    // Access fault response.
    req_ready = 1'b1;
    tick();
    rsp_valid = 1'b1;
    rsp_err   = 1'b1;
    rsp_data  = 32'hABCD_1234;
    tick();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    check("fault instr_valid", 32'(instr_valid), 32'd1);
    check("fault fetch_fault", 32'(fetch_fault), 32'd1);
    check("fault instr", instr, 32'h0);
    check("fault instr_pc", instr_pc, 32'h8000_0008);

    // Redirect with exec_ready in HOLD: target wins over pc+4.
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0300;
    exec_ready  = 1'b1;
    tick();
    redirect   = 1'b0;
    exec_ready = 1'b0;
    check("hold redir req_valid", 32'(req_valid), 32'd1);
    check("hold redir req_addr", req_addr, 32'h8000_0300);
    check("hold redir instr_valid", 32'(instr_valid), 32'd0);

    // Asynchronous reset in WAIT.
    tick();
    check("pre-reset req_valid", 32'(req_valid), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async reset");

    // With fetch disabled the unit stays idle after reset.
    rst      = 1'b0;
    fetch_en = 1'b0;
    tick();
    tick();
    check("idle req_valid", 32'(req_valid), 32'd0);
    check("idle req_addr", req_addr, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_core_fetch
